cordic_rr_scheduler: RTL and testbench

- Shares one `cordic_instr_top` CORDIC engine between NREQ independent requesters, e.g. several peripheral register front-ends or a DMA-style job queue.
- Arbitrates round-robin and latches the winning job (theta, sin/cos mode).
- Sequences the engine's start/done handshake, screens invalid inputs, and routes the float32 result back to the originating requester, tagged with its ID.
- Sits between the requester front-ends and a single engine instance.

---
 rtl/cordic_rr_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_cordic_rr_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rr_scheduler.sv
// Round-robin front-end that shares one CORDIC engine between NREQ requesters.
// Optional watchdog on the engine handshake: define CORDIC_SCHED_TIMEOUT_EN.
module cordic_rr_scheduler #(
    parameter int NREQ           = 2,
    parameter int IDW            = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_theta,
    input  logic [NREQ-1:0]      req_cos,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [31:0]          core_dataa,
    output logic                 core_cos,
    output logic                 core_start,
    input  logic                 core_done,
    input  logic [31:0]          core_result,
    input  logic                 core_invalid
`ifdef CORDIC_SCHED_TIMEOUT_EN
    ,
    output logic                 timeout_seen
`endif
);

    localparam int CW = IDW + 1;
    localparam int IDW_EXP = (NREQ <= 2) ? 1 : $clog2(NREQ);
    localparam logic [31:0] NAN_VALUE = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [IDW-1:0]   cur_id_r;
    logic             grant_vld_s;
    logic [IDW-1:0]   grant_id_s;
    logic [IDW-1:0]   next_ptr_s;
    logic [CW-1:0]    sum_s;
    logic [CW-1:0]    cand_s;
    logic [31:0]      theta_arr_s [NREQ];

    if (NREQ < 2 || NREQ > 8 || IDW != IDW_EXP || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("cordic_rr_scheduler: illegal NREQ/IDW/TIMEOUT_CYCLES combination");
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_theta
        assign theta_arr_s[g] = req_theta[32*g +: 32];
    end

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_r;
`endif

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = {IDW{1'b0}};
        sum_s       = {CW{1'b0}};
        cand_s      = {CW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            sum_s  = {1'b0, rr_ptr_r} + CW'(k);
            cand_s = (sum_s >= CW'(NREQ)) ? (sum_s - CW'(NREQ)) : sum_s;
            if (!grant_vld_s && req_valid[cand_s[IDW-1:0]] && (state_r == IDLE)) begin
                grant_vld_s = 1'b1;
                grant_id_s  = cand_s[IDW-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // One-hot grant decode and pointer advance past the winner.
    always_comb begin
        req_ready  = {NREQ{1'b0}};
        next_ptr_s = (grant_id_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (grant_id_s + IDW'(1));
        if (grant_vld_s) begin
            req_ready[grant_id_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Sequencer: accept, screen, run the engine, return the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            rr_ptr_r   <= {IDW{1'b0}};
            cur_id_r   <= {IDW{1'b0}};
            core_dataa <= 32'h0000_0000;
            core_cos   <= 1'b0;
            core_start <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= {IDW{1'b0}};
            rsp_data   <= 32'h0000_0000;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            tmo_cnt_r    <= {TW{1'b0}};
            timeout_seen <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            rsp_valid  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_vld_s) begin
                        core_dataa <= theta_arr_s[grant_id_s];
                        core_cos   <= req_cos[grant_id_s];
                        cur_id_r   <= grant_id_s;
                        rr_ptr_r   <= next_ptr_s;
                        busy       <= 1'b1;
                        state_r    <= CHECK;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                CHECK: begin
                    if (core_invalid) begin
                        rsp_data  <= NAN_VALUE;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id_r;
                        state_r   <= RESP;
                    end else begin
                        core_start <= 1'b1;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                        tmo_cnt_r  <= {TW{1'b0}};
`endif
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        rsp_data  <= core_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id_r;
                        state_r   <= RESP;
                    end
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    else if (tmo_cnt_r == TW'(TIMEOUT_CYCLES)) begin
                        rsp_data     <= NAN_VALUE;
                        rsp_err      <= 1'b1;
                        rsp_valid    <= 1'b1;
                        rsp_id       <= cur_id_r;
                        timeout_seen <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                        state_r   <= RUN;
                    end
`else
                    else begin
                        state_r <= RUN;
                    end
`endif
                end
                RESP: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Randomized bench for cordic_rr_scheduler with a timestamp-level job model and engine stub.
// Define CORDIC_SCHED_TIMEOUT_EN to also exercise the watchdog.
module tb_cordic_rr_scheduler;

    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam int TMO  = 64;
    localparam logic [31:0] NAN_VALUE = 32'h7FC0_0000;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_theta;
    logic [NREQ-1:0]     req_cos;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_data;
    logic                rsp_err;
    logic                busy;
    logic [31:0]         core_dataa;
    logic                core_cos;
    logic                core_start;
    logic                core_done;
    logic [31:0]         core_result;
    logic                core_invalid;
`ifdef CORDIC_SCHED_TIMEOUT_EN
    logic                timeout_seen;
`endif

    cordic_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_theta(req_theta), .req_cos(req_cos),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy),
        .core_dataa(core_dataa), .core_cos(core_cos), .core_start(core_start),
        .core_done(core_done), .core_result(core_result), .core_invalid(core_invalid)
`ifdef CORDIC_SCHED_TIMEOUT_EN
        , .timeout_seen(timeout_seen)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // job model: everything about a job is fixed by timestamps at acceptance
    bit          job_on = 1'b0;
    int          j_id, j_accept, j_start, j_rsp;
    logic [31:0] j_theta, j_data;
    logic        j_cos, j_err;
    bit          j_tmo;
    int          rr = 0;
    bit          tmo_flag = 1'b0;
    bit          chk_zero = 1'b0;

    // engine stub and stimulus state
    int          stub_done = -1;
    int          stub_lat = 1;
    logic [31:0] stub_res = 32'h0;
    int          force_lat = 0;
    logic [31:0] force_res = 32'h0;
    bit          never_done = 1'b0;
    bit          stray = 1'b0;
    logic [31:0] th [NREQ];
    logic [NREQ-1:0] cosv = '0;
    int          obs_grants[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit is_invalid(input logic [31:0] t);
        return t[30:23] == 8'hFF;
    endfunction

    task automatic tick(input logic [NREQ-1:0] v, input logic rst);
        logic [NREQ-1:0] exp_rdy;
        int g;
        @(negedge clk);
        if (job_on && j_tmo && cyc == j_rsp) tmo_flag = 1'b1;
        check("busy", 32'(busy), 32'(job_on));
        check("core_start", 32'(core_start), 32'(job_on && cyc == j_start));
        check("rsp_valid", 32'(rsp_valid), 32'(job_on && cyc == j_rsp));
        if (job_on && cyc == j_rsp) begin
            check("rsp_id", 32'(rsp_id), 32'(j_id));
            check("rsp_data", rsp_data, j_data);
            check("rsp_err", 32'(rsp_err), 32'(j_err));
        end
        if (job_on && cyc > j_accept) begin
            check("core_dataa", core_dataa, j_theta);
            check("core_cos", 32'(core_cos), 32'(j_cos));
        end
        if (chk_zero) begin
            chk_zero = 1'b0;
            check("rst_dataa", core_dataa, 32'h0);
            check("rst_cos", 32'(core_cos), 32'h0);
            check("rst_rsp_data", rsp_data, 32'h0);
            check("rst_rsp_id", 32'(rsp_id), 32'h0);
            check("rst_rsp_err", 32'(rsp_err), 32'h0);
        end
`ifdef CORDIC_SCHED_TIMEOUT_EN
        check("timeout_seen", 32'(timeout_seen), 32'(tmo_flag));
`endif
        if (core_start) stub_done = cyc + stub_lat;
        reset     = rst;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) req_theta[32*i +: 32] = th[i];
        req_cos      = cosv;
        core_invalid = is_invalid(core_dataa);
        core_done    = stray || (cyc == stub_done && !never_done);
        core_result  = stub_res;
        #1;
        g = job_on ? -1 : pick(v, rr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < NREQ; i++) if (req_ready[i] && v[i]) obs_grants.push_back(i);
        if (job_on && cyc == j_rsp) job_on = 1'b0;
        if (rst) begin
            job_on = 1'b0; rr = 0; stub_done = -1; tmo_flag = 1'b0; chk_zero = 1'b1;
        end else if (g >= 0) begin
            job_on   = 1'b1;
            j_id     = g;
            j_accept = cyc;
            j_theta  = th[g];
            j_cos    = cosv[g];
            rr       = (g + 1) % NREQ;
            stub_lat = (force_lat > 0) ? force_lat : $urandom_range(1, 8);
            stub_res = (force_lat > 0) ? force_res : $urandom;
            if (is_invalid(th[g])) begin
                j_start = -1; j_rsp = cyc + 2; j_data = NAN_VALUE; j_err = 1'b1; j_tmo = 1'b0;
            end else if (never_done) begin
                j_start = cyc + 2; j_rsp = cyc + 2 + TMO + 1; j_data = NAN_VALUE; j_err = 1'b1; j_tmo = 1'b1;
            end else begin
                j_start = cyc + 2; j_rsp = cyc + 3 + stub_lat; j_data = stub_res; j_err = 1'b0; j_tmo = 1'b0;
            end
        end
        cyc++;
    endtask

    initial begin
        int base;
        int lim;
        reset = 1'b1; req_valid = '0; req_theta = '0; req_cos = '0;
        core_done = 1'b0; core_result = 32'h0; core_invalid = 1'b0;
        for (int i = 0; i < NREQ; i++) th[i] = 32'h3F80_0000;
        repeat (2) @(negedge clk);
        chk_zero = 1'b1;
        tick('0, 1'b0);

        // stray done while idle
        stray = 1'b1;
        tick('0, 1'b0);
        stray = 1'b0;
        repeat (3) tick('0, 1'b0);

        // single cosine job on requester 0, engine answers 20 cycles after start
        th[0] = 32'h3F80_0000; cosv = 2'b01;
        force_lat = 20; force_res = 32'h3F0A_5140;
        tick(2'b01, 1'b0);
        repeat (26) tick('0, 1'b0);
        force_lat = 0;

        // invalid theta on requester 1
        th[1] = 32'h7F80_0000; cosv = 2'b00;
        tick(2'b10, 1'b0);
        repeat (4) tick('0, 1'b0);

        // both requesters held high for four jobs
        th[0] = 32'h3F00_1234; th[1] = 32'h3E80_5678;
        base = obs_grants.size();
        lim = 0;
        while (obs_grants.size() < base + 4 && lim < 200) begin
            tick(2'b11, 1'b0);
            lim++;
        end
        check("rr_jobs", 32'(obs_grants.size() - base), 32'd4);
        for (int k = 0; k < 4 && base + k < obs_grants.size(); k++)
            check("rr_order", 32'(obs_grants[base + k]), 32'(k % 2));
        repeat (15) tick('0, 1'b0);

        // reset five cycles after core_start, then fresh jobs
        force_lat = 30; force_res = 32'h1234_5678;
        tick(2'b01, 1'b0);
        lim = 0;
        while (cyc < j_start + 5 && lim < 20) begin
            tick('0, 1'b0);
            lim++;
        end
        tick('0, 1'b1);
        force_lat = 0;
        tick('0, 1'b0);
        th[1] = 32'h3F40_0000;
        tick(2'b10, 1'b0);
        repeat (14) tick('0, 1'b0);
        base = obs_grants.size();
        tick(2'b11, 1'b0);
        check("rr_after_rst", (obs_grants.size() > base) ? 32'(obs_grants[base]) : 32'hFFFF_FFFF, 32'd0);
        repeat (14) tick('0, 1'b0);

`ifdef CORDIC_SCHED_TIMEOUT_EN
        // engine never finishes: watchdog answers
        never_done = 1'b1;
        th[0] = 32'h3F80_0000;
        tick(2'b01, 1'b0);
        repeat (72) tick('0, 1'b0);
        never_done = 1'b0;
`endif

        // random traffic with a mix of invalid angles
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                th[i] = $urandom;
                if ($urandom_range(0, 3) == 0) th[i][30:23] = 8'hFF;
                else if (th[i][30:23] == 8'hFF) th[i][23] = 1'b0;
            end
            cosv = NREQ'($urandom);
            tick(NREQ'($urandom), 1'b0);
        end
        repeat (20) tick('0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
